// File: rtl/addsub_pkg.sv
// Shared definitions for the addsub operand pair aligner.
package addsub_pkg;
  localparam int DEF_WIDTH = 32;

  typedef logic [1:0] state_t;

  localparam state_t PAIR   = 2'd0;
  localparam state_t DROP_A = 2'd1;
  localparam state_t DROP_B = 2'd2;
endpackage

// File: rtl/axis_skid2.sv
// Two-entry AXI-stream skid buffer with a registered ready.
module axis_skid2 #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_pop
);
  logic [1:0]   cnt_q, cnt_d, occ;
  logic [W-1:0] mem0_q, mem0_d;
  logic [W-1:0] mem1_q, mem1_d;
  logic         ready_q, ready_d;
  logic         push, pop;

  always_comb begin
    push   = in_valid && ready_q;
    pop    = out_pop && (cnt_q != 2'd0);
    occ    = cnt_q - {1'b0, pop};
    cnt_d  = occ + {1'b0, push};
    mem0_d = pop ? mem1_q : mem0_q;
    mem1_d = mem1_q;
    if (push) begin
      if (occ == 2'd0) mem0_d = in_data;
      else             mem1_d = in_data;
    end
    ready_d = (cnt_d != 2'd2);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= 2'd0;
      ready_q <= 1'b0;
      mem0_q  <= '0;
      mem1_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      mem0_q  <= mem0_d;
      mem1_q  <= mem1_d;
    end
  end

  assign in_ready  = ready_q;
  assign out_data  = mem0_q;
  assign out_valid = (cnt_q != 2'd0);
endmodule

// File: rtl/addsub_pair_aligner.sv
// Lockstep pairing of two sample streams into the addsub core,
// truncating pairs and dropping the long tail on tlast mismatch.
module addsub_pair_aligner
  import addsub_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int COUNT_W = 16
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic [WIDTH-1:0]   a_i_tdata,
  input  logic               a_i_tlast,
  input  logic               a_i_tvalid,
  output logic               a_i_tready,
  input  logic [WIDTH-1:0]   b_i_tdata,
  input  logic               b_i_tlast,
  input  logic               b_i_tvalid,
  output logic               b_i_tready,
  output logic [WIDTH-1:0]   a_o_tdata,
  output logic               a_o_tlast,
  output logic               a_o_tvalid,
  input  logic               a_o_tready,
  output logic [WIDTH-1:0]   b_o_tdata,
  output logic               b_o_tlast,
  output logic               b_o_tvalid,
  input  logic               b_o_tready,
  output logic               mismatch_stb,
  output logic [COUNT_W-1:0] mismatch_count
);
  logic [WIDTH:0]     a_head, b_head;
  logic               a_hv, b_hv, a_pop, b_pop;
  logic               a_free, b_free, load, mism;
  state_t             state_q, state_d;
  logic               a_full_q, a_full_d, b_full_q, b_full_d;
  logic [WIDTH-1:0]   a_data_q, a_data_d, b_data_q, b_data_d;
  logic               a_last_q, a_last_d, b_last_q, b_last_d;
  logic               stb_q, stb_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;

  axis_skid2 #(.W(WIDTH+1)) u_skid_a (
    .clk(ap_clk), .rst_n(ap_rst_n),
    .in_data({a_i_tlast, a_i_tdata}), .in_valid(a_i_tvalid),
    .in_ready(a_i_tready),
    .out_data(a_head), .out_valid(a_hv), .out_pop(a_pop)
  );

  axis_skid2 #(.W(WIDTH+1)) u_skid_b (
    .clk(ap_clk), .rst_n(ap_rst_n),
    .in_data({b_i_tlast, b_i_tdata}), .in_valid(b_i_tvalid),
    .in_ready(b_i_tready),
    .out_data(b_head), .out_valid(b_hv), .out_pop(b_pop)
  );

  always_comb begin
    a_free = !a_full_q || a_o_tready;
    b_free = !b_full_q || b_o_tready;
    load   = (state_q == PAIR) && a_hv && b_hv && a_free && b_free;
    a_pop  = load || ((state_q == DROP_A) && a_hv);
    b_pop  = load || ((state_q == DROP_B) && b_hv);
    mism   = load && (a_head[WIDTH] != b_head[WIDTH]);

    a_full_d = load || (a_full_q && !a_o_tready);
    b_full_d = load || (b_full_q && !b_o_tready);
    a_data_d = load ? a_head[WIDTH-1:0] : a_data_q;
    b_data_d = load ? b_head[WIDTH-1:0] : b_data_q;
    // a lone tlast closes both lanes so the core sees one packet
    a_last_d = load ? (a_head[WIDTH] | b_head[WIDTH]) : a_last_q;
    b_last_d = load ? (a_head[WIDTH] | b_head[WIDTH]) : b_last_q;

    stb_d = mism;
    cnt_d = cnt_q;
    if (mism && (cnt_q != '1)) cnt_d = cnt_q + COUNT_W'(1);

    state_d = state_q;
    case (state_q)
      PAIR:
        if (mism) state_d = a_head[WIDTH] ? DROP_B : DROP_A;
      DROP_A:
        if (a_hv && a_head[WIDTH]) state_d = PAIR;
      DROP_B:
        if (b_hv && b_head[WIDTH]) state_d = PAIR;
      default:
        state_d = PAIR;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q  <= PAIR;
      a_full_q <= 1'b0;
      b_full_q <= 1'b0;
      a_data_q <= '0;
      b_data_q <= '0;
      a_last_q <= 1'b0;
      b_last_q <= 1'b0;
      stb_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_full_q <= a_full_d;
      b_full_q <= b_full_d;
      a_data_q <= a_data_d;
      b_data_q <= b_data_d;
      a_last_q <= a_last_d;
      b_last_q <= b_last_d;
      stb_q    <= stb_d;
      cnt_q    <= cnt_d;
    end
  end

  assign a_o_tdata      = a_data_q;
  assign a_o_tlast      = a_last_q;
  assign a_o_tvalid     = a_full_q;
  assign b_o_tdata      = b_data_q;
  assign b_o_tlast      = b_last_q;
  assign b_o_tvalid     = b_full_q;
  assign mismatch_stb   = stb_q;
  assign mismatch_count = cnt_q;
endmodule

// File: tb/tb_addsub_pair_aligner.sv
// Randomized scoreboard bench for addsub_pair_aligner, with a
// second instance using a 2-bit counter for saturation checks.
module tb_addsub_pair_aligner;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a_i_tdata = '0, b_i_tdata = '0;
  logic        a_i_tlast = 1'b0, b_i_tlast = 1'b0;
  logic        a_i_tvalid = 1'b0, b_i_tvalid = 1'b0;
  logic        a_i_tready, b_i_tready;
  logic [31:0] a_o_tdata, b_o_tdata;
  logic        a_o_tlast, b_o_tlast, a_o_tvalid, b_o_tvalid;
  logic        a_o_tready = 1'b0, b_o_tready = 1'b0;
  logic        stb1;
  logic [15:0] cnt1;
  logic        a_i_tready2, b_i_tready2;
  logic [31:0] a_o_tdata2, b_o_tdata2;
  logic        a_o_tlast2, b_o_tlast2, a_o_tvalid2, b_o_tvalid2;
  logic        stb2;
  logic [1:0]  cnt2;

  addsub_pair_aligner dut (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .a_i_tdata(a_i_tdata), .a_i_tlast(a_i_tlast),
    .a_i_tvalid(a_i_tvalid), .a_i_tready(a_i_tready),
    .b_i_tdata(b_i_tdata), .b_i_tlast(b_i_tlast),
    .b_i_tvalid(b_i_tvalid), .b_i_tready(b_i_tready),
    .a_o_tdata(a_o_tdata), .a_o_tlast(a_o_tlast),
    .a_o_tvalid(a_o_tvalid), .a_o_tready(a_o_tready),
    .b_o_tdata(b_o_tdata), .b_o_tlast(b_o_tlast),
    .b_o_tvalid(b_o_tvalid), .b_o_tready(b_o_tready),
    .mismatch_stb(stb1), .mismatch_count(cnt1)
  );

  addsub_pair_aligner #(.COUNT_W(2)) dut2 (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .a_i_tdata(a_i_tdata), .a_i_tlast(a_i_tlast),
    .a_i_tvalid(a_i_tvalid), .a_i_tready(a_i_tready2),
    .b_i_tdata(b_i_tdata), .b_i_tlast(b_i_tlast),
    .b_i_tvalid(b_i_tvalid), .b_i_tready(b_i_tready2),
    .a_o_tdata(a_o_tdata2), .a_o_tlast(a_o_tlast2),
    .a_o_tvalid(a_o_tvalid2), .a_o_tready(a_o_tready),
    .b_o_tdata(b_o_tdata2), .b_o_tlast(b_o_tlast2),
    .b_o_tvalid(b_o_tvalid2), .b_o_tready(b_o_tready),
    .mismatch_stb(stb2), .mismatch_count(cnt2)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  int a_start = 0, b_start = 0, in_rate = 100;
  int a_rmode = 0, b_rmode = 0, b_hold = 0;
  int mism = 0, stb_seen1 = 0, stb_seen2 = 0;
  bit flush = 1'b0;
  logic [32:0] a_src[$], b_src[$], exp_a[$], exp_b[$];
  logic [31:0] pa[$], pb[$];

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // packet-level model: pairs up to the shorter length, last pair closes
  task automatic commit();
    int n;
    n = (pa.size() < pb.size()) ? pa.size() : pb.size();
    for (int i = 0; i < n; i++) begin
      exp_a.push_back({i == n - 1, pa[i]});
      exp_b.push_back({i == n - 1, pb[i]});
    end
    if (pa.size() != pb.size()) mism++;
    for (int i = 0; i < pa.size(); i++)
      a_src.push_back({i == pa.size() - 1, pa[i]});
    for (int i = 0; i < pb.size(); i++)
      b_src.push_back({i == pb.size() - 1, pb[i]});
    pa.delete();
    pb.delete();
  endtask

  task automatic rnd_pkts(input int la, input int lb);
    for (int i = 0; i < la; i++) pa.push_back($urandom);
    for (int i = 0; i < lb; i++) pb.push_back($urandom);
    commit();
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while ((a_src.size() != 0 || b_src.size() != 0 ||
            exp_a.size() != 0 || exp_b.size() != 0 ||
            a_i_tvalid || b_i_tvalid) && t < 3000) begin
      @(posedge clk);
      t++;
    end
    repeat (8) @(posedge clk);
    checks++;
    if (t >= 3000) begin
      failures++;
      $display("FAIL %s_drain: timeout left a=%0d b=%0d", tag,
               exp_a.size(), exp_b.size());
    end
  endtask

  task automatic chk_counts(input string tag);
    int sat;
    sat = (mism > 3) ? 3 : mism;
    @(negedge clk);
    chk({tag, "_count"}, 64'(cnt1), 64'(mism));
    chk({tag, "_stb"}, 64'(stb_seen1), 64'(mism));
    chk({tag, "_count2"}, 64'(cnt2), 64'(sat));
    chk({tag, "_stb2"}, 64'(stb_seen2), 64'(mism));
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // lane A source
  initial begin
    bit fire;
    forever begin
      @(negedge clk);
      fire = a_i_tvalid && a_i_tready;
      @(posedge clk);
      #1;
      if (fire || flush) a_i_tvalid = 1'b0;
      if (flush) a_src.delete();
      if (!a_i_tvalid && a_src.size() != 0 && cyc >= a_start &&
          $urandom_range(99) < in_rate) begin
        {a_i_tlast, a_i_tdata} = a_src.pop_front();
        a_i_tvalid = 1'b1;
      end
    end
  end

  // lane B source
  initial begin
    bit fire;
    forever begin
      @(negedge clk);
      fire = b_i_tvalid && b_i_tready;
      @(posedge clk);
      #1;
      if (fire || flush) b_i_tvalid = 1'b0;
      if (flush) b_src.delete();
      if (!b_i_tvalid && b_src.size() != 0 && cyc >= b_start &&
          $urandom_range(99) < in_rate) begin
        {b_i_tlast, b_i_tdata} = b_src.pop_front();
        b_i_tvalid = 1'b1;
      end
    end
  end

  // sink readies: 0 always, 1 toggle, 2 random, 3 stalled
  initial forever begin
    @(posedge clk);
    #1;
    case (a_rmode)
      0:       a_o_tready = 1'b1;
      1:       a_o_tready = ~a_o_tready;
      2:       a_o_tready = ($urandom_range(99) < 65);
      default: a_o_tready = 1'b0;
    endcase
    if (b_hold > 0) begin
      b_o_tready = 1'b0;
      b_hold--;
    end else begin
      case (b_rmode)
        0:       b_o_tready = 1'b1;
        1:       b_o_tready = ~b_o_tready;
        2:       b_o_tready = ($urandom_range(99) < 65);
        default: b_o_tready = 1'b0;
      endcase
    end
  end

  // monitor / scoreboard
  initial begin
    bit a_pend, b_pend;
    logic [32:0] a_held, b_held, e;
    a_pend = 1'b0;
    b_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (flush) begin
        exp_a.delete();
        exp_b.delete();
        stb_seen1 = 0;
        stb_seen2 = 0;
      end
      if (!rst_n) begin
        a_pend = 1'b0;
        b_pend = 1'b0;
      end else begin
        if (a_pend) begin
          checks++;
          if (!a_o_tvalid || {a_o_tlast, a_o_tdata} != a_held) begin
            failures++;
            $display("FAIL hold_a: got v=%0b %0h required v=1 %0h",
                     a_o_tvalid, {a_o_tlast, a_o_tdata}, a_held);
          end
        end
        if (b_pend) begin
          checks++;
          if (!b_o_tvalid || {b_o_tlast, b_o_tdata} != b_held) begin
            failures++;
            $display("FAIL hold_b: got v=%0b %0h required v=1 %0h",
                     b_o_tvalid, {b_o_tlast, b_o_tdata}, b_held);
          end
        end
        if (a_o_tvalid && a_o_tready) begin
          checks++;
          if (exp_a.size() == 0) begin
            failures++;
            $display("FAIL out_a: got %0h required nothing",
                     {a_o_tlast, a_o_tdata});
          end else begin
            e = exp_a.pop_front();
            if ({a_o_tlast, a_o_tdata} != e) begin
              failures++;
              $display("FAIL out_a: got %0h required %0h",
                       {a_o_tlast, a_o_tdata}, e);
            end
          end
        end
        if (b_o_tvalid && b_o_tready) begin
          checks++;
          if (exp_b.size() == 0) begin
            failures++;
            $display("FAIL out_b: got %0h required nothing",
                     {b_o_tlast, b_o_tdata});
          end else begin
            e = exp_b.pop_front();
            if ({b_o_tlast, b_o_tdata} != e) begin
              failures++;
              $display("FAIL out_b: got %0h required %0h",
                       {b_o_tlast, b_o_tdata}, e);
            end
          end
        end
        a_pend = a_o_tvalid && !a_o_tready;
        b_pend = b_o_tvalid && !b_o_tready;
        a_held = {a_o_tlast, a_o_tdata};
        b_held = {b_o_tlast, b_o_tdata};
        if (stb1) stb_seen1++;
        if (stb2) stb_seen2++;
      end
    end
  end

  initial begin
    int la, lb, t, base;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_o_tvalid", 64'(a_o_tvalid), 0);
    chk("rst_b_o_tvalid", 64'(b_o_tvalid), 0);
    chk("rst_a_i_tready", 64'(a_i_tready), 0);
    chk("rst_b_i_tready", 64'(b_i_tready), 0);
    chk("rst_stb", 64'(stb1), 0);
    chk("rst_count", 64'(cnt1), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // equal packets, sinks always ready
    a_start = cyc;
    b_start = cyc;
    pa = '{32'd1, 32'd2, 32'd3, 32'd4};
    pb = '{32'd10, 32'd20, 32'd30, 32'd40};
    commit();
    wait_idle("equal");
    chk_counts("equal");

    // skew and backpressure
    a_rmode = 1;
    b_hold = 3;
    a_start = cyc;
    b_start = cyc + 5;
    rnd_pkts(6, 6);
    wait_idle("skew");
    chk_counts("skew");
    a_rmode = 0;

    // B long then a short equal packet
    pa = '{32'd1, 32'd2};
    pb = '{32'd10, 32'd20, 32'd30, 32'd40};
    commit();
    pa = '{32'd7};
    pb = '{32'd70};
    commit();
    wait_idle("b_long");
    chk_counts("b_long");

    // A long, symmetric
    pa = '{32'd1, 32'd2, 32'd3, 32'd4};
    pb = '{32'd10, 32'd20};
    commit();
    pa = '{32'd7};
    pb = '{32'd70};
    commit();
    wait_idle("a_long");
    chk_counts("a_long");

    // five more mismatches under random flow control
    in_rate = 70;
    a_rmode = 2;
    b_rmode = 2;
    for (int i = 0; i < 5; i++) begin
      la = $urandom_range(1, 5);
      do lb = $urandom_range(1, 5); while (lb == la);
      rnd_pkts(la, lb);
    end
    wait_idle("sat");
    chk_counts("sat");

    // mixed random traffic
    for (int i = 0; i < 12; i++) begin
      la = $urandom_range(1, 6);
      lb = ($urandom_range(1) == 1) ? la : $urandom_range(1, 6);
      rnd_pkts(la, lb);
    end
    wait_idle("rand");
    chk_counts("rand");

    // reset while dropping B with both output regs held full
    in_rate = 100;
    a_rmode = 3;
    b_rmode = 3;
    base = stb_seen1;
    rnd_pkts(1, 16);
    t = 0;
    while (stb_seen1 == base && t < 100) begin
      @(posedge clk);
      t++;
    end
    chk("mid_reset_mismatch_seen", 64'(t < 100), 1);
    repeat (2) @(posedge clk);
    chk("mid_reset_out_full", 64'(a_o_tvalid & b_o_tvalid), 1);
    #2;
    rst_n = 1'b0;
    flush = 1'b1;
    mism = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    flush = 1'b0;
    @(negedge clk);
    chk("post_rst_a_o_tvalid", 64'(a_o_tvalid), 0);
    chk("post_rst_b_o_tvalid", 64'(b_o_tvalid), 0);
    chk("post_rst_a_i_tready", 64'(a_i_tready), 0);
    chk("post_rst_count", 64'(cnt1), 0);
    chk("post_rst_count2", 64'(cnt2), 0);
    chk("post_rst_stb", 64'(stb1), 0);

    // fresh packets pair from their first sample
    a_rmode = 0;
    b_rmode = 0;
    a_start = cyc;
    b_start = cyc;
    pa = '{32'd100, 32'd101, 32'd102};
    pb = '{32'd200, 32'd201, 32'd202};
    commit();
    wait_idle("fresh");
    chk_counts("fresh");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
